// File: rtl/vc_qspi.sv
// rtl/vc_qspi.sv - quad-SPI memory port: 0xEB burst reads and 0x38 writes, SCK at clk/2
module vc_qspi #(
    parameter int PA    = 24,
    parameter int BURST = 4,
    parameter int DUMMY = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [PA-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    input  logic          req_size,
    output logic          rd_valid,
    output logic [15:0]   rd_data,
    output logic          rd_last,
    output logic          done,
    output logic          spi_cs_n,
    output logic          spi_clk,
    output logic [3:0]    spi_dout,
    output logic [3:0]    spi_oe,
    input  logic [3:0]    spi_din
);
    localparam int SW = 8 + PA + 16;
    localparam int AN = PA / 4;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_DESEL
    } state_t;

    state_t        state;
    logic [SW-1:0] sr;
    logic [5:0]    nib;
    logic          wr;
    logic          sz;
    logic [15:0]   rx;
    logic [15:0]   rx_next;
    logic          last_nib;

    assign req_ready = (state == ST_IDLE) & ~reset;
    assign rx_next   = {rx[11:0], spi_din};

    always_comb begin
        last_nib = 1'b0;
        case (state)
            ST_CMD:   last_nib = (nib == 6'd1);
            ST_ADDR:  last_nib = (nib == 6'(AN - 1));
            ST_DUMMY: last_nib = (nib == 6'(DUMMY - 1));
            ST_RDATA: last_nib = (nib == 6'(2 * BURST - 1));
            ST_WDATA: last_nib = (nib == (sz ? 6'd3 : 6'd1));
            default:  last_nib = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            sr       <= '0;
            nib      <= '0;
            wr       <= 1'b0;
            sz       <= 1'b0;
            rx       <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_dout <= 4'h0;
            spi_oe   <= 4'h0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state    <= ST_CMD;
                        wr       <= req_write;
                        sz       <= req_size;
                        sr       <= {(req_write ? 8'h38 : 8'hEB), req_addr,
                                     req_wdata[7:0], req_wdata[15:8]};
                        spi_dout <= req_write ? 4'h3 : 4'hE;
                        spi_oe   <= 4'hF;
                        spi_cs_n <= 1'b0;
                        spi_clk  <= 1'b0;
                        nib      <= '0;
                    end
                end
                ST_DESEL: begin
                    if (nib == 6'd1) begin
                        state <= ST_IDLE;
                        nib   <= '0;
                    end else begin
                        nib <= nib + 6'd1;
                    end
                end
                default: begin
                    spi_clk <= ~spi_clk;
                    // Every SCK falling edge closes one nibble: sample input, present next output.
                    if (spi_clk) begin
                        sr       <= sr << 4;
                        spi_dout <= sr[SW-5 -: 4];
                        nib      <= last_nib ? 6'd0 : nib + 6'd1;
                        if (state == ST_RDATA) begin
                            rx <= rx_next;
                            if (nib[1:0] == 2'd3) begin
                                rd_valid <= 1'b1;
                                rd_data  <= {rx_next[7:0], rx_next[15:8]};
                                rd_last  <= last_nib;
                            end
                        end
                        if (last_nib) begin
                            case (state)
                                ST_CMD:   state <= ST_ADDR;
                                ST_ADDR: begin
                                    state  <= wr ? ST_WDATA : ST_DUMMY;
                                    spi_oe <= wr ? 4'hF : 4'h0;
                                end
                                ST_DUMMY: state <= ST_RDATA;
                                default: begin
                                    state    <= ST_DESEL;
                                    spi_cs_n <= 1'b1;
                                    spi_oe   <= 4'h0;
                                    spi_dout <= 4'h0;
                                    spi_clk  <= 1'b0;
                                    done     <= (state == ST_WDATA);
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/vc_qspi.md
VC_QSPI -- requirements
Module: vc_qspi

Interface
REQ-001 SHALL have parameter PA, default 24, meaning physical address width in bits.
REQ-002 SHALL have parameter BURST, default 4, meaning bytes per read; legal values are even, 2..16.
REQ-003 SHALL have parameter DUMMY, default 6, meaning read dummy SCK cycles.
REQ-004 SHALL have port clk, input, width 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, width 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, width 1, meaning a cache/CPU memory request is present.
REQ-007 SHALL have port req_ready, output, width 1, meaning the request is accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_write, input, width 1, meaning 1 = write, 0 = burst read.
REQ-009 SHALL have port req_addr, input, width PA, meaning the byte address.
REQ-010 SHALL have port req_wdata, input, width 16, meaning write data; byte 0 is [7:0].
REQ-011 SHALL have port req_size, input, width 1, meaning write size: 0 = 1 byte, 1 = 2 bytes.
REQ-012 SHALL have port rd_valid, output, width 1, meaning a one-cycle pulse when rd_data holds a new halfword.
REQ-013 SHALL have port rd_data, output, width 16, meaning read halfword, little-endian.
REQ-014 SHALL have port rd_last, output, width 1, meaning asserted with the final rd_valid of a burst.
REQ-015 SHALL have port done, output, width 1, meaning a one-cycle pulse when a write completes (cs_n returns high).
REQ-016 SHALL have port spi_cs_n, output, width 1, meaning the external QSPI chip select.
REQ-017 SHALL have port spi_clk, output, width 1, meaning the external QSPI SCK.
REQ-018 SHALL have port spi_dout, output, width 4, meaning the quad data out.
REQ-019 SHALL have port spi_oe, output, width 4, meaning the pad output enable (1 = drive).
REQ-020 SHALL have port spi_din, input, width 4, meaning the quad data in.

Function
REQ-021 SHALL implement states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, DESEL.
REQ-022 SHALL drive req_ready = (state==IDLE) & ~reset, combinationally.
REQ-023 SHALL capture addr/wdata/size/write on accept; later input changes are ignored until the next accept.
REQ-024 SHALL, on the accept edge, enter CMD and drive spi_cs_n low in the following cycle.
REQ-025 SHALL run SCK at clk/2: spi_clk toggles every clk while in CMD..WDATA, starting low.
REQ-026 SHALL change spi_dout only while spi_clk=0, and sample spi_din on the clk edge where spi_clk goes 1->0.
REQ-027 SHALL send all fields nibble-serial, most significant nibble first.
REQ-028 SHALL, in CMD, send 0xEB for a read or 0x38 for a write (2 SCK, 4 clk).
REQ-029 SHALL, in ADDR, send PA/4 nibbles of the captured address (6 SCK for PA=24), unmodified with no wrap handling.
REQ-030 SHALL, for a read, follow ADDR with DUMMY: DUMMY SCK with spi_oe=0000.
REQ-031 SHALL, in RDATA, sample 2*BURST nibbles and pulse rd_valid every 4 nibbles; the first byte goes to rd_data[7:0].
REQ-032 SHALL, in WDATA, send 2 nibbles (size 0) or 4 nibbles (size 1), byte 0 first.
REQ-033 SHALL drive spi_oe=1111 in CMD, ADDR, WDATA and 0000 otherwise.
REQ-034 SHALL hold rd_data stable between pulses.
REQ-035 SHALL enter DESEL after the last data nibble: spi_cs_n=1 and spi_clk=0 for exactly 2 clk, then IDLE.
REQ-036 SHALL pulse done in the first DESEL cycle of a write.
REQ-037 SHALL coincide rd_last with the final rd_valid.
REQ-038 SHALL be ready to accept again in the cycle after DESEL; back-to-back requests give a cs_n-high gap of >=2 clk.
REQ-039 SHALL make a BURST=4 read take 4+12+12+16 clk from the first cs_n-low cycle to the last rd_valid.

Reset
REQ-040 SHALL reset state to IDLE, spi_cs_n=1, spi_clk=0, spi_oe=0000, spi_dout=0000, rd_valid=0, rd_last=0, done=0, rd_data=0.
REQ-041 SHALL, on reset mid-transfer, abort: spi_cs_n=1 and spi_oe=0000 on the next edge, with no rd_valid or done issued for the aborted request.
REQ-042 SHALL keep reset dominant over a simultaneous req_valid, so no accept occurs.

Verification
REQ-043 SHALL test a read at 0x123456 with a model returning bytes 0x11,0x22,0x33,0x44 -> CMD nibbles E,B; address nibbles 1..6; rd_data 0x2211 then 0x4433 with rd_last.
REQ-044 SHALL test a write of 0xBEEF with size=1 at 0x000010 -> nibbles 3,8,0,0,0,0,1,0,E,F,B,E; done pulses once; cs_n high 2 clk.
REQ-045 SHALL test a byte write with size=0 -> only 2 data nibbles, spi_oe=1111 throughout, and done.
REQ-046 SHALL test reset asserted in the DUMMY state -> cs_n=1 next clk; no rd_valid; the next read completes normally.
REQ-047 SHALL test back-to-back reads with req_valid held high -> second accept exactly 2 clk after cs_n rises, and payload changes during a busy transfer ignored.
REQ-048 SHALL test BURST=16 -> 8 rd_valid pulses, with rd_last only on the 8th.
